// File: rtl/stmt_loop_sequencer.sv
// Multi-cycle loop sequencer: runs while / do-while / forever / repeat loops by
// driving a body datapath over req/ack, with an iteration watchdog and abort.
module stmt_loop_sequencer #(
    parameter int CNT_W    = 8,
    parameter int MAX_ITER = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             cond,
    input  logic             abort,
    output logic             body_req,
    input  logic             body_ack,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             aborted,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [1:0] {IDLE, CHECK, BODY, DONE} state_t;

    localparam logic [1:0]       M_WHILE    = 2'b00;
    localparam logic [1:0]       M_DO       = 2'b01;
    localparam logic [1:0]       M_FOREVER  = 2'b10;
    localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             cont_next;
    logic [CNT_W-1:0] iter_next;

    always_comb begin
        cont_next = 1'b0;
        case (mode_reg)
            M_WHILE, M_DO: cont_next = cond;
            M_FOREVER:     cont_next = 1'b1;
            default:       cont_next = (remaining_reg != '0);
        endcase
    end

    assign iter_next = iter_count + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= 2'b00;
            remaining_reg <= '0;
            body_req      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            aborted       <= 1'b0;
            iter_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg      <= mode;
                        remaining_reg <= count;
                        iter_count    <= '0;
                        timeout       <= 1'b0;
                        aborted       <= 1'b0;
                        busy          <= 1'b1;
                        // Bottom-tested loops enter the body without a check.
                        if (mode == M_DO || mode == M_FOREVER) begin
                            state_reg <= BODY;
                            body_req  <= 1'b1;
                        end else begin
                            state_reg <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state_reg <= DONE;
                        aborted   <= 1'b1;
                        done      <= 1'b1;
                    end else if (cont_next) begin
                        state_reg <= BODY;
                        body_req  <= 1'b1;
                    end else begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end
                end
                BODY: begin
                    // Abort beats a coincident ack; that iteration is discarded.
                    if (abort) begin
                        state_reg <= DONE;
                        body_req  <= 1'b0;
                        aborted   <= 1'b1;
                        done      <= 1'b1;
                    end else if (body_ack) begin
                        body_req   <= 1'b0;
                        iter_count <= iter_next;
                        if (mode_reg == 2'b11 && remaining_reg != '0)
                            remaining_reg <= remaining_reg - CNT_W'(1);
                        if (iter_next == ITER_LIMIT) begin
                            state_reg <= DONE;
                            timeout   <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= CHECK;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stmt_loop_sequencer.sv
// Scoreboard bench for stmt_loop_sequencer: directed loop runs, expected results
// queued at launch and checked by a monitor whenever done pulses.
module tb_stmt_loop_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_wd = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] count = 8'd0;
    logic       cond;
    logic       abort = 1'b0;
    logic       body_ack = 1'b0;

    logic       body_req, busy, done, timeout, aborted;
    logic [7:0] iter_count;
    logic       body_req_wd, busy_wd, done_wd, timeout_wd, aborted_wd;
    logic [7:0] iter_count_wd;

    stmt_loop_sequencer #(.CNT_W(8), .MAX_ITER(200)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .count(count),
        .cond(cond), .abort(abort), .body_req(body_req), .body_ack(body_ack),
        .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
        .iter_count(iter_count)
    );

    // Second instance with a small watchdog limit for the forever-loop case.
    stmt_loop_sequencer #(.CNT_W(8), .MAX_ITER(4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .start(start_wd), .mode(mode), .count(count),
        .cond(cond), .abort(abort), .body_req(body_req_wd), .body_ack(body_ack),
        .busy(busy_wd), .done(done_wd), .timeout(timeout_wd), .aborted(aborted_wd),
        .iter_count(iter_count_wd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Body responder: acks after ack_delay idle cycles, optionally aborts on an ack.
    int ack_delay = 0;
    int abort_at = 0;
    int cond_limit = 0;
    int wait_cnt = 0;
    int acks_issued = 0;
    assign cond = (acks_issued < cond_limit);

    always @(negedge clk) begin
        abort = 1'b0;
        if (!busy && !busy_wd) acks_issued = 0;
        if (body_req || body_req_wd) begin
            if (wait_cnt >= ack_delay) begin
                body_ack = 1'b1;
                wait_cnt = 0;
                acks_issued++;
                if (acks_issued == abort_at) abort = 1'b1;
            end else begin
                body_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            body_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monotonic body_req statistics for the main instance.
    int  req_cycles = 0;
    int  req_rises = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (body_req) req_cycles++;
        if (body_req && !req_prev) req_rises++;
        req_prev = body_req;
    end

    typedef struct {
        int src;
        int iter;
        bit to;
        bit ab;
        int lat;
    } exp_t;
    exp_t sb[$];
    int   accept_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && (done || done_wd)) begin
            exp_t e;
            int   a_src, a_iter, a_lat;
            bit   a_to, a_ab;
            a_src  = done_wd ? 1 : 0;
            a_iter = done_wd ? int'(iter_count_wd) : int'(iter_count);
            a_to   = done_wd ? timeout_wd : timeout;
            a_ab   = done_wd ? aborted_wd : aborted;
            a_lat  = cyc - accept_cyc;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: src=%0d iter=%0d, no run outstanding", a_src, a_iter);
            end else begin
                e = sb.pop_front();
                if (a_src != e.src || a_iter != e.iter || a_to != e.to || a_ab != e.ab) begin
                    fails++;
                    $display("FAIL done_result: got src=%0d iter=%0d timeout=%0b aborted=%0b, expected src=%0d iter=%0d timeout=%0b aborted=%0b",
                             a_src, a_iter, a_to, a_ab, e.src, e.iter, e.to, e.ab);
                end else begin
                    $display("[TB] done src=%0d iter=%0d timeout=%0b aborted=%0b", a_src, a_iter, a_to, a_ab);
                end
                if (e.lat >= 0) begin
                    tests++;
                    if (a_lat != e.lat) begin
                        fails++;
                        $display("FAIL done_latency: got %0d cycles, expected %0d", a_lat, e.lat);
                    end
                end
            end
        end
    end

    task automatic launch(input bit wd, input logic [1:0] m, input logic [7:0] c,
                          input int it, input bit to, input bit ab, input int lat);
        exp_t e;
        @(negedge clk);
        e.src = wd ? 1 : 0;
        e.iter = it;
        e.to = to;
        e.ab = ab;
        e.lat = lat;
        sb.push_back(e);
        mode = m;
        count = c;
        if (wd) start_wd = 1'b1;
        else start = 1'b1;
        accept_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        start_wd = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || busy_wd) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy || busy_wd) begin
            fails++;
            $display("FAIL %s_finish: still busy after %0d cycles, expected idle", name, n);
        end
        @(negedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("[TB] %s = %0d", name, got);
        end
    endtask

    initial begin
        int r0, c0, n;

        #12;
        check_int("reset_body_req", int'(body_req), 0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_iter_count", int'(iter_count), 0);
        check_int("reset_flags", int'({timeout, aborted}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // while: cond true for 3 checks, immediate ack
        ack_delay = 0; cond_limit = 3; abort_at = 0;
        r0 = req_rises;
        launch(1'b0, 2'b00, 8'd0, 3, 1'b0, 1'b0, -1);
        wait_idle("while");
        check_int("while_req_pulses", req_rises - r0, 3);

        // do-while, cond false throughout
        cond_limit = 0;
        r0 = req_rises;
        launch(1'b0, 2'b01, 8'd0, 1, 1'b0, 1'b0, -1);
        wait_idle("dowhile");
        check_int("dowhile_req_pulses", req_rises - r0, 1);

        // repeat 5 with ack delayed 2 cycles
        ack_delay = 2;
        r0 = req_rises;
        c0 = req_cycles;
        launch(1'b0, 2'b11, 8'd5, 5, 1'b0, 1'b0, -1);
        wait_idle("repeat5");
        check_int("repeat5_req_pulses", req_rises - r0, 5);
        check_int("repeat5_req_cycles", req_cycles - c0, 15);

        // forever on the watchdog instance, with a stray start mid-run
        ack_delay = 0;
        launch(1'b1, 2'b10, 8'd0, 4, 1'b1, 1'b0, -1);
        repeat (2) @(negedge clk);
        start_wd = 1'b1;
        mode = 2'b00;
        @(negedge clk);
        start_wd = 1'b0;
        wait_idle("forever");
        check_int("forever_iter_hold", int'(iter_count_wd), 4);

        // repeat 10 aborted on the 3rd ack, then repeat 0
        abort_at = 3;
        launch(1'b0, 2'b11, 8'd10, 2, 1'b0, 1'b1, -1);
        wait_idle("abort");
        abort_at = 0;
        launch(1'b0, 2'b11, 8'd0, 0, 1'b0, 1'b0, 2);
        wait_idle("repeat0");

        // asynchronous reset in the middle of the second body execution
        ack_delay = 1;
        @(negedge clk);
        mode = 2'b11;
        count = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(body_req && iter_count == 8'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("pre_reset_iter", int'(iter_count), 1);
        #2 rst_n = 1'b0;
        #1;
        check_int("async_rst_body_req", int'(body_req), 0);
        check_int("async_rst_busy", int'(busy), 0);
        check_int("async_rst_iter_count", int'(iter_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        launch(1'b0, 2'b11, 8'd1, 1, 1'b0, 1'b0, -1);
        wait_idle("post_reset");

        check_int("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
